// File: rtl/serial_alu.sv
// Bit-serial ALU: one 1-bit slice reused over WIDTH cycles, LSB first, valid/ready on both sides.
// Optional SERIAL_ALU_LOGIC_BYPASS_EN: AND/OR resolved in parallel at accept, skipping the serial pass.
module serial_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, FIX, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] aSh_q, bSh_q, resSh_q, result_q;
  logic             ainv_q, binv_q, carry_q, msbSum_q, ovfInt_q;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic             reqReady_q, rspValid_q, zero_q, cout_q, ovf_q;

  logic             aBit, bBit, sumBit, sliceBit, carry_d, lastBit;
  logic [WIDTH-1:0] resSh_d;

  // The single ALU slice operating on the current LSB of the operand shifters
  always_comb begin
    aBit    = aSh_q[0] ^ ainv_q;
    bBit    = bSh_q[0] ^ binv_q;
    sumBit  = aBit ^ bBit ^ carry_q;
    carry_d = (aBit & bBit) | (aBit & carry_q) | (bBit & carry_q);
    case (op_q)
      2'b00:   sliceBit = aBit & bBit;
      2'b01:   sliceBit = aBit | bBit;
      2'b10:   sliceBit = sumBit;
      default: sliceBit = 1'b0;
    endcase
    resSh_d = {sliceBit, resSh_q[WIDTH-1:1]};
    lastBit = (cnt_q == CW'(WIDTH - 1));
  end

`ifdef SERIAL_ALU_LOGIC_BYPASS_EN
  logic [WIDTH-1:0] bypA, bypB, bypRes;
  always_comb begin
    bypA   = src1 ^ {WIDTH{ALU_control[3]}};
    bypB   = src2 ^ {WIDTH{ALU_control[2]}};
    bypRes = ALU_control[0] ? (bypA | bypB) : (bypA & bypB);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      reqReady_q <= 1'b1;
      rspValid_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      aSh_q      <= '0;
      bSh_q      <= '0;
      resSh_q    <= '0;
      ainv_q     <= 1'b0;
      binv_q     <= 1'b0;
      op_q       <= 2'b00;
      msbSum_q   <= 1'b0;
      ovfInt_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && reqReady_q) begin
            reqReady_q <= 1'b0;
`ifdef SERIAL_ALU_LOGIC_BYPASS_EN
            if (!ALU_control[1]) begin
              result_q   <= bypRes;
              zero_q     <= (bypRes == '0);
              cout_q     <= 1'b0;
              ovf_q      <= 1'b0;
              rspValid_q <= 1'b1;
              state_q    <= DONE;
            end else begin
`else
            begin
`endif
              aSh_q   <= src1;
              bSh_q   <= src2;
              resSh_q <= '0;
              ainv_q  <= ALU_control[3];
              binv_q  <= ALU_control[2];
              op_q    <= ALU_control[1:0];
              carry_q <= ALU_control[2];
              cnt_q   <= '0;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          aSh_q   <= aSh_q >> 1;
          bSh_q   <= bSh_q >> 1;
          carry_q <= carry_d;
          resSh_q <= resSh_d;
          if (!lastBit) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cout_q   <= op_q[1] ? carry_d : 1'b0;
            ovf_q    <= (op_q == 2'b10) ? (carry_q ^ carry_d) : 1'b0;
            ovfInt_q <= carry_q ^ carry_d;
            msbSum_q <= sumBit;
            if (op_q == 2'b11) begin
              state_q <= FIX;
            end else begin
              result_q   <= resSh_d;
              zero_q     <= (resSh_d == '0);
              rspValid_q <= 1'b1;
              state_q    <= DONE;
            end
          end
        end
        FIX: begin
          // Signed less-than: sign of the difference corrected by overflow
          result_q   <= {{(WIDTH-1){1'b0}}, msbSum_q ^ ovfInt_q};
          zero_q     <= ~(msbSum_q ^ ovfInt_q);
          rspValid_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rspValid_q <= 1'b0;
            reqReady_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = reqReady_q;
  assign rsp_valid = rspValid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu: directed ops, backpressure, mid-op reset.
// Honours SERIAL_ALU_LOGIC_BYPASS_EN for the expected logic-op latency.
module tb_serial_alu;

  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic [3:0]  aluControl = '0;
  logic        rspValid;
  logic        rspReady = 1'b0;
  logic [31:0] result;
  logic        zero, cout, overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        z, c, o;
    int          lat;
  } exp_t;

  exp_t sb[$];

  serial_alu #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(reqReady),
    .src1(src1), .src2(src2), .ALU_control(aluControl),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .result(result),
    .zero(zero), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference: whole-word arithmetic, independent of the serial structure
  function automatic exp_t model(input logic [31:0] s1, input logic [31:0] s2, input logic [3:0] c);
    exp_t        e;
    logic [31:0] a, b;
    logic [32:0] s;
    logic        ovf;
    a   = s1 ^ {32{c[3]}};
    b   = s2 ^ {32{c[2]}};
    s   = {1'b0, a} + {1'b0, b} + {32'b0, c[2]};
    ovf = (a[31] == b[31]) && (s[31] != a[31]);
    e.c = 1'b0;
    e.o = 1'b0;
    case (c[1:0])
      2'b00: e.res = a & b;
      2'b01: e.res = a | b;
      2'b10: begin e.res = s[31:0]; e.c = s[32]; e.o = ovf; end
      default: begin e.res = {31'b0, s[31] ^ ovf}; e.c = s[32]; end
    endcase
    e.z = (e.res == 32'b0);
    if (c[1:0] == 2'b11) e.lat = WIDTH + 2;
`ifdef SERIAL_ALU_LOGIC_BYPASS_EN
    else if (!c[1]) e.lat = 1;
`endif
    else e.lat = WIDTH + 1;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure latency, compare against the scoreboard, then release
  task automatic applyStimulus(input logic [31:0] s1, input logic [31:0] s2, input logic [3:0] c,
                               input bit inject, input int hold);
    exp_t        e;
    int          n;
    logic [31:0] heldRes;
    @(negedge clk);
    checkOutput("req_ready_idle", {63'b0, reqReady}, 64'd1);
    src1 = s1; src2 = s2; aluControl = c; reqValid = 1'b1;
    sb.push_back(model(s1, s2, c));
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    src1 = $urandom; src2 = $urandom; aluControl = 4'($urandom);
    n = 1;
    while (rspValid !== 1'b1 && n < 80) begin
      if (inject && n == 4) begin
        reqValid = 1'b1; src1 = 32'h1234_5678; src2 = 32'h0000_0001; aluControl = 4'b0010;
      end else begin
        reqValid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    reqValid = 1'b0;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    checkOutput("latency", 64'(n), 64'(e.lat));
    checkOutput("result", {32'b0, result}, {32'b0, e.res});
    checkOutput("zero", {63'b0, zero}, {63'b0, e.z});
    checkOutput("cout", {63'b0, cout}, {63'b0, e.c});
    checkOutput("overflow", {63'b0, overflow}, {63'b0, e.o});
    heldRes = e.res;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", {63'b0, rspValid}, 64'd1);
      checkOutput("hold_ready", {63'b0, reqReady}, 64'd0);
      checkOutput("hold_result", {32'b0, result}, {32'b0, heldRes});
      checkOutput("hold_flags", {61'b0, zero, cout, overflow}, {61'b0, e.z, e.c, e.o});
    end
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    checkOutput("release_ready", {63'b0, reqReady}, 64'd1);
    checkOutput("release_valid", {63'b0, rspValid}, 64'd0);
    checkOutput("idle_result_hold", {32'b0, result}, {32'b0, heldRes});
  endtask

  initial begin
    $display("[TB] serial_alu bench start");
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", {63'b0, reqReady}, 64'd1);
    checkOutput("rst_rsp_valid", {63'b0, rspValid}, 64'd0);
    checkOutput("rst_result", {32'b0, result}, 64'd0);
    checkOutput("rst_flags", {61'b0, zero, cout, overflow}, 64'd0);
    rst = 1'b0;

    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 1'b0, 0);
    applyStimulus(32'd5,         32'd5,         4'b0110, 1'b0, 0);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 4'b0111, 1'b0, 0);
    applyStimulus(32'h7FFF_FFFF, 32'h8000_0000, 4'b0111, 1'b0, 0);
    applyStimulus(32'hF0F0_0000, 32'hFF00_FF00, 4'b0000, 1'b0, 0);
    applyStimulus(32'h0000_0000, 32'h0000_0000, 4'b1100, 1'b0, 0);
    applyStimulus(32'h1234_0000, 32'h0000_00F0, 4'b0001, 1'b0, 0);
    applyStimulus(32'h0000_0010, 32'h0000_0003, 4'b0010, 1'b1, 5);

    for (int i = 0; i < 4; i++) begin
      logic [3:0] c;
      c = {1'b0, 1'($urandom), 2'($urandom)};
      applyStimulus($urandom, $urandom, c, 1'b0, 1);
    end

    // Reset mid-operation discards the in-flight ADD
    @(negedge clk);
    src1 = 32'd100; src2 = 32'd200; aluControl = 4'b0010; reqValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_req_ready", {63'b0, reqReady}, 64'd1);
    checkOutput("midrst_rsp_valid", {63'b0, rspValid}, 64'd0);
    checkOutput("midrst_result", {32'b0, result}, 64'd0);
    applyStimulus(32'd3, 32'd4, 4'b0010, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
